register_file: RTL and testbench

REGISTER_FILE -- requirements
Module: register_file

---
 rtl/register_file.sv | 85 ++++++++
 tb/tb_register_file.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : register_file                                                 |
// | Purpose  : NUM_REGS x DATA_WIDTH register file, one write port and two   |
// |            independent registered read ports (1-cycle latency).          |
// | Options  : REGFILE_BYPASS_EN (set in register_cfg.v) forwards same-edge  |
// |            write data to a matching read port.                           |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module register_file #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_REGS   = 64,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            read_en,
    input  logic                  write_en,
    input  logic [ADDR_WIDTH-1:0] raddr_0,
    input  logic [ADDR_WIDTH-1:0] raddr_1,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata_0,
    output logic [DATA_WIDTH-1:0] rdata_1
);

    logic [DATA_WIDTH-1:0] RF [0:NUM_REGS-1];

    logic [DATA_WIDTH-1:0] r_rdata_0;
    logic [DATA_WIDTH-1:0] r_rdata_1;

    logic                  w_waddr_ok;
    logic                  w_raddr0_ok;
    logic                  w_raddr1_ok;
    logic                  w_byp_0;
    logic                  w_byp_1;
    logic [DATA_WIDTH-1:0] w_rd_0;
    logic [DATA_WIDTH-1:0] w_rd_1;

    // Out-of-range addresses only exist when NUM_REGS is not a power of two.
    assign w_waddr_ok  = (32'(waddr)   < 32'(NUM_REGS));
    assign w_raddr0_ok = (32'(raddr_0) < 32'(NUM_REGS));
    assign w_raddr1_ok = (32'(raddr_1) < 32'(NUM_REGS));

    assign w_rd_0 = w_raddr0_ok ? RF[raddr_0] : '0;
    assign w_rd_1 = w_raddr1_ok ? RF[raddr_1] : '0;

`ifdef REGFILE_BYPASS_EN
    assign w_byp_0 = write_en && w_waddr_ok && (raddr_0 == waddr);
    assign w_byp_1 = write_en && w_waddr_ok && (raddr_1 == waddr);
`else
    assign w_byp_0 = 1'b0;
    assign w_byp_1 = 1'b0;
`endif

    // Reset is active-high despite the port name.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                RF[i] <= '0;
            end
        end else if (write_en && w_waddr_ok) begin
            RF[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            r_rdata_0 <= '0;
            r_rdata_1 <= '0;
        end else begin
            if (read_en[0]) begin
                r_rdata_0 <= w_byp_0 ? wdata : w_rd_0;
            end
            if (read_en[1]) begin
                r_rdata_1 <= w_byp_1 ? wdata : w_rd_1;
            end
        end
    end

    assign rdata_0 = r_rdata_0;
    assign rdata_1 = r_rdata_1;

endmodule
`default_nettype wire

// File: tb/tb_register_file.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_register_file                                              |
// | Purpose  : directed and randomized checks of register_file against an    |
// |            array-based reference model.                                  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_register_file;

    localparam int DW = 64;
    localparam int NR = 64;
    localparam int AW = 6;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic [1:0]    read_en;
    logic          write_en;
    logic [AW-1:0] raddr_0;
    logic [AW-1:0] raddr_1;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata_0;
    logic [DW-1:0] rdata_1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] m_rf [NR];
    logic [DW-1:0] m_r0;
    logic [DW-1:0] m_r1;

    register_file #(.DATA_WIDTH(DW), .NUM_REGS(NR), .ADDR_WIDTH(AW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .read_en (read_en),
        .write_en(write_en),
        .raddr_0 (raddr_0),
        .raddr_1 (raddr_1),
        .waddr   (waddr),
        .wdata   (wdata),
        .rdata_0 (rdata_0),
        .rdata_1 (rdata_1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic idle();
        reset_n  = 1'b0;
        read_en  = 2'b00;
        write_en = 1'b0;
        raddr_0  = '0;
        raddr_1  = '0;
        waddr    = '0;
        wdata    = '0;
    endtask

    // One clock edge: the model applies the edge's semantics, then outputs are compared.
    task automatic step(input string tag);
        @(posedge clk);
        if (reset_n) begin
            for (int i = 0; i < NR; i++) m_rf[i] = '0;
            m_r0 = '0;
            m_r1 = '0;
        end else begin
            if (read_en[0]) m_r0 = (BYPASS && write_en && raddr_0 == waddr) ? wdata : m_rf[raddr_0];
            if (read_en[1]) m_r1 = (BYPASS && write_en && raddr_1 == waddr) ? wdata : m_rf[raddr_1];
            if (write_en) m_rf[waddr] = wdata;
        end
        #1;
        check({tag, ".rdata_0"}, rdata_0, m_r0);
        check({tag, ".rdata_1"}, rdata_1, m_r1);
    endtask

    task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        idle();
        write_en = 1'b1;
        waddr    = a;
        wdata    = d;
        step("wr");
    endtask

    task automatic check_array(input string tag);
        for (int i = 0; i < NR; i++) check($sformatf("%s.RF[%0d]", tag, i), dut.RF[i], m_rf[i]);
    endtask

    initial begin
        logic [DW-1:0] prev1;
        logic [DW-1:0] exp_v;
        m_r0 = 'x;
        m_r1 = 'x;
        idle();
        #1;

        // Reset held for ten cycles
        reset_n = 1'b1;
        for (int c = 0; c < 10; c++) step("reset");
        idle();
        for (int i = 0; i < NR; i++) check($sformatf("reset.RF[%0d]", i), dut.RF[i], '0);
        check("reset.rdata_0", rdata_0, '0);
        check("reset.rdata_1", rdata_1, '0);

        // Fill and read back on both ports
        for (int i = 0; i < NR; i++) write(AW'(i), DW'(i) * 64'h0101010101010101);
        for (int i = 0; i < NR; i++) begin
            idle();
            read_en = 2'b11;
            raddr_0 = AW'(i);
            raddr_1 = AW'(i);
            step("fill_rd");
            exp_v = DW'(i) * 64'h0101010101010101;
            check($sformatf("fill_rd%0d.p0", i), rdata_0, exp_v);
            check($sformatf("fill_rd%0d.p1", i), rdata_1, exp_v);
        end

        // Single-port read; port 1 holds
        write(5, 64'hDEADBEEF);
        prev1 = rdata_1;
        idle();
        read_en = 2'b01;
        raddr_0 = 5;
        raddr_1 = 9;
        step("p0_only");
        check("p0_only.rdata_0", rdata_0, 64'hDEADBEEF);
        check("p0_only.rdata_1_hold", rdata_1, prev1);

        // Same-edge write/read of one address
        write(7, 64'h11);
        idle();
        write_en = 1'b1;
        waddr    = 7;
        wdata    = 64'hA5;
        read_en  = 2'b11;
        raddr_0  = 7;
        raddr_1  = 7;
        step("wr_rd");
        exp_v = BYPASS ? 64'hA5 : 64'h11;
        check("wr_rd.rdata_0", rdata_0, exp_v);
        check("wr_rd.rdata_1", rdata_1, exp_v);
        check("wr_rd.RF7", dut.RF[7], 64'hA5);

        // Reset beats a concurrent write
        idle();
        reset_n  = 1'b1;
        write_en = 1'b1;
        waddr    = 3;
        wdata    = 64'hFF;
        read_en  = 2'b11;
        step("rst_wr");
        check("rst_wr.RF3", dut.RF[3], '0);
        check("rst_wr.rdata_0", rdata_0, '0);
        check("rst_wr.rdata_1", rdata_1, '0);
        check_array("rst_wr");

        // Top address, neighbours untouched
        write(0, 64'h0123456789ABCDEF);
        write(62, 64'h5555AAAA5555AAAA);
        write(63, 64'hFFFFFFFFFFFFFFFF);
        idle();
        read_en = 2'b11;
        raddr_0 = 63;
        raddr_1 = 62;
        step("top");
        check("top.rdata_0", rdata_0, 64'hFFFFFFFFFFFFFFFF);
        check("top.rdata_1", rdata_1, 64'h5555AAAA5555AAAA);
        check("top.RF62", dut.RF[62], 64'h5555AAAA5555AAAA);
        check("top.RF0", dut.RF[0], 64'h0123456789ABCDEF);

        // Randomized traffic; address range narrowed to force collisions
        for (int c = 0; c < 600; c++) begin
            reset_n  = ($urandom_range(0, 79) == 0);
            write_en = $urandom_range(0, 1) == 1;
            read_en  = 2'($urandom_range(0, 3));
            waddr    = AW'($urandom_range(0, 15));
            raddr_0  = AW'($urandom_range(0, 15));
            raddr_1  = ($urandom_range(0, 3) == 0) ? raddr_0 : AW'($urandom_range(0, 15));
            wdata    = {$urandom, $urandom};
            step("rand");
        end
        idle();
        check_array("rand_end");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
